rv32_mem_arbiter: RTL and testbench

Shares one memory bus between the fetch stage's instruction port and the memory stage's data port. This lets the core run against a single-port memory instead of split instruction/data memories.
- Arbitration: data has fixed priority over instructions, with a starvation guard.
- Routing: a source-ID FIFO returns each in-order read response to the requester that issued it.
- Placement: between the core's fetch/memory stages and the memory; the core stalls on missing grants.

---
 rtl/rv32_mem_arbiter.sv | 118 +++++++++++
 tb/tb_rv32_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mem_arbiter.sv
// Shares one memory bus between the fetch (instr) and memory-stage (data) ports.
// Data has fixed priority, with a starvation guard; a source-ID FIFO routes the in-order responses back.
module rv32_mem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic [3:0]  data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST   = PW'(MAX_OUTSTANDING - 1);
  localparam logic [3:0]    STARVE_MAX = 4'(STARVE_LIMIT);

  // state  | meaning
  // IDLE   | no handshake pending; source chosen by priority
  // LOCK_I | instr request presented but not yet accepted; hold it on the bus
  // LOCK_D | data request presented but not yet accepted; hold it on the bus
  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} lock_e;
  lock_e state, state_nxt;

  logic                   sel;
  logic                   req_sel;
  logic                   grant;
  logic                   pop;
  logic                   spurious;
  logic                   head;
  logic                   err;
  logic [MAX_OUTSTANDING-1:0] src_q;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic [3:0]             starve_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sel       = 1'b0;
    case (state)
      LOCK_I:  sel = 1'b0;
      LOCK_D:  sel = 1'b1;
      default: sel = (starve_cnt == STARVE_MAX && instr_req_i) ? 1'b0 : data_req_i;
    endcase
    // A full FIFO drops mem_req_o, so an existing lock simply persists.
    if (grant)          state_nxt = IDLE;
    else if (mem_req_o) state_nxt = sel ? LOCK_D : LOCK_I;
  end

  assign req_sel     = sel ? data_req_i : instr_req_i;
  assign mem_req_o   = !rst_i && req_sel && (count < CNT_MAX);
  assign grant       = mem_req_o && mem_gnt_i;
  assign instr_gnt_o = grant && !sel;
  assign data_gnt_o  = grant && sel;
  assign mem_addr_o  = sel ? data_addr_i  : instr_addr_i;
  assign mem_we_o    = sel ? data_we_i    : 4'b0000;
  assign mem_wdata_o = sel ? data_wdata_i : 32'h0;

  assign head           = src_q[rd_ptr];
  assign pop            = !rst_i && mem_rvalid_i && (count != '0);
  assign spurious       = mem_rvalid_i && (count == '0);
  assign instr_rvalid_o = pop && !head;
  assign data_rvalid_o  = pop && head;
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
  assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : 32'h0;
  assign busy_o         = !rst_i && (count != '0);
  assign err_o          = !rst_i && err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      err        <= 1'b0;
    end else begin
      if (grant) begin
        src_q[wr_ptr] <= sel;
        wr_ptr        <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      if (grant && !pop)      count <= count + 1'b1;
      else if (pop && !grant) count <= count - 1'b1;
      if (spurious) err <= 1'b1;
      if (instr_gnt_o || !instr_req_i)
        starve_cnt <= '0;
      else if (data_gnt_o && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Bench for rv32_mem_arbiter: directed vectors, expected grants/responses queued and checked by a monitor.
module tb_rv32_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic [3:0]  data_we_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o, err_o;

  rv32_mem_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic src; logic [31:0] val; } exp_t;  // src: 1 = data
  exp_t gnt_q[$];
  exp_t rsp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_gnt(input logic src, input logic [31:0] addr);
    gnt_q.push_back({src, addr});
  endtask

  task automatic exp_rsp(input logic src, input logic [31:0] data);
    rsp_q.push_back({src, data});
  endtask

  // Monitor: every grant and every response must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (instr_gnt_o || data_gnt_o) begin
      checks++;
      if (gnt_q.size() == 0) begin
        errors++;
        $display("FAIL gnt_unexpected: instr=%0b data=%0b addr=0x%08h", instr_gnt_o, data_gnt_o, mem_addr_o);
      end else begin
        e = gnt_q.pop_front();
        if (instr_gnt_o && data_gnt_o || data_gnt_o !== e.src || mem_addr_o !== e.val) begin
          errors++;
          $display("FAIL gnt: got instr=%0b data=%0b addr=0x%08h expected src=%0b addr=0x%08h",
                   instr_gnt_o, data_gnt_o, mem_addr_o, e.src, e.val);
        end
      end
    end
    if (instr_rvalid_o || data_rvalid_o) begin
      checks++;
      if (rsp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: instr=%0b data=%0b", instr_rvalid_o, data_rvalid_o);
      end else begin
        e = rsp_q.pop_front();
        if (instr_rvalid_o && data_rvalid_o || data_rvalid_o !== e.src ||
            (e.src ? data_rdata_o : instr_rdata_o) !== e.val ||
            (e.src ? instr_rdata_o : data_rdata_o) !== 32'h0) begin
          errors++;
          $display("FAIL rsp: got irv=%0b ird=0x%08h drv=%0b drd=0x%08h expected src=%0b data=0x%08h",
                   instr_rvalid_o, instr_rdata_o, data_rvalid_o, data_rdata_o, e.src, e.val);
        end
      end
    end
  end

  logic prio_seq [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst_i = 1'b1; instr_req_i = 1'b1; instr_addr_i = 32'h1000;
    data_req_i = 1'b1; data_we_i = 4'h0; data_addr_i = 32'h2000; data_wdata_i = 32'h0;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;

    // Reset with requests and bus grant active
    tick();
    @(negedge clk);
    chk("rst_instr_gnt", {31'h0, instr_gnt_o}, 32'h0);
    chk("rst_data_gnt", {31'h0, data_gnt_o}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    tick();
    rst_i = 1'b0;

    // Priority / starvation: D,D,D,D,I,D,D,D,D,I with one-cycle responses
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) tick();
      mem_rvalid_i = (k > 0);
      mem_rdata_i  = 32'hC000_0000 + k;
      if (k == 10) begin instr_req_i = 1'b0; data_req_i = 1'b0; end
      if (k < 10) begin
        exp_gnt(prio_seq[k], prio_seq[k] ? 32'h2000 : 32'h1000);
        exp_rsp(prio_seq[k], 32'hC000_0000 + k + 1);
      end
    end
    tick();
    mem_rvalid_i = 1'b0;

    // Lock: data held on the bus across stalled cycles
    mem_gnt_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h300;
    @(negedge clk);
    chk("lock_req", {31'h0, mem_req_o}, 32'h1);
    chk("lock_addr1", mem_addr_o, 32'h300);
    tick();
    instr_req_i = 1'b1;
    @(negedge clk);
    chk("lock_addr2", mem_addr_o, 32'h300);
    chk("lock_nogrant", {30'h0, instr_gnt_o, data_gnt_o}, 32'h0);
    tick();
    @(negedge clk);
    chk("lock_addr3", mem_addr_o, 32'h300);
    tick();
    mem_gnt_i = 1'b1;
    exp_gnt(1'b1, 32'h300);
    exp_rsp(1'b1, 32'h0000_5555);
    tick();
    data_req_i = 1'b0;
    exp_gnt(1'b0, 32'h1000);
    exp_rsp(1'b0, 32'h0000_6666);
    tick();
    instr_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_5555;
    tick();
    mem_rdata_i = 32'h0000_6666;
    tick();
    mem_rvalid_i = 1'b0;

    // Full: four reads accepted, then no request until a response drains one
    data_req_i = 1'b1; data_addr_i = 32'h400;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      exp_gnt(1'b1, 32'h400);
    end
    tick();
    @(negedge clk);
    chk("full_mem_req", {31'h0, mem_req_o}, 32'h0);
    chk("full_busy", {31'h0, busy_o}, 32'h1);
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7000_0001;
    exp_rsp(1'b1, 32'h7000_0001);
    @(negedge clk);
    chk("full_pop_mem_req", {31'h0, mem_req_o}, 32'h0);
    tick();
    mem_rvalid_i = 1'b0;
    exp_gnt(1'b1, 32'h400);
    @(negedge clk);
    chk("refill_mem_req", {31'h0, mem_req_o}, 32'h1);
    for (int k = 2; k <= 5; k++) begin
      tick();
      data_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7000_0000 + k;
      exp_rsp(1'b1, 32'h7000_0000 + k);
    end
    tick();
    mem_rvalid_i = 1'b0;
    @(negedge clk);
    chk("drain_busy", {31'h0, busy_o}, 32'h0);

    // Routing: instr read, data write, data read
    tick();
    instr_req_i = 1'b1; instr_addr_i = 32'h100; data_we_i = 4'hF; data_wdata_i = 32'hFFFF_FFFF;
    exp_gnt(1'b0, 32'h100);
    exp_rsp(1'b0, 32'hAAAA_0000);
    @(negedge clk);
    chk("instr_we", {28'h0, mem_we_o}, 32'h0);
    chk("instr_wdata", mem_wdata_o, 32'h0);
    tick();
    instr_req_i = 1'b0; data_req_i = 1'b1; data_we_i = 4'b0011;
    data_addr_i = 32'h180; data_wdata_i = 32'hDEAD_BEEF;
    exp_gnt(1'b1, 32'h180);
    exp_rsp(1'b1, 32'h0);
    @(negedge clk);
    chk("wr_we", {28'h0, mem_we_o}, 32'h3);
    chk("wr_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    tick();
    data_we_i = 4'h0; data_addr_i = 32'h200;
    exp_gnt(1'b1, 32'h200);
    exp_rsp(1'b1, 32'h1234_5678);
    tick();
    data_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA_0000;
    tick();
    mem_rdata_i = 32'h0;
    tick();
    mem_rdata_i = 32'h1234_5678;
    tick();
    mem_rvalid_i = 1'b0;

    // Spurious response with nothing outstanding
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0BAD;
    @(negedge clk);
    chk("spur_rvalid", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h0);
    chk("spur_err_early", {31'h0, err_o}, 32'h0);
    tick();
    mem_rvalid_i = 1'b0;
    @(negedge clk);
    chk("spur_err_set", {31'h0, err_o}, 32'h1);
    chk("spur_busy", {31'h0, busy_o}, 32'h0);
    tick(); tick();
    @(negedge clk);
    chk("spur_err_held", {31'h0, err_o}, 32'h1);
    tick();
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst_err_clr", {31'h0, err_o}, 32'h0);
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_err", {31'h0, err_o}, 32'h0);

    tick(); tick();
    chk("gnt_q_left", gnt_q.size(), 32'h0);
    chk("rsp_q_left", rsp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
